// File: rtl/spmv_row_mac_pkg.sv
// Shared SpMV definitions: row-MAC FSM states and element word layout.
// Element fields are given as slot indices; bit position = slot * DATA_WIDTH.
package spmv_row_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  // Element word = {mat_val, vec_val}
  localparam int MAT_LSB = 1;
  localparam int VEC_LSB = 0;

endpackage

// File: rtl/spmv_mac_unit.sv
// Combinational signed multiply-accumulate step for the SpMV row MAC.
// Kept separate so the product path can be pipelined without touching the FSM.
module spmv_mac_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 64
) (
  input  logic [ACC_WIDTH-1:0]  i_acc,
  input  logic [DATA_WIDTH-1:0] i_mat,
  input  logic [DATA_WIDTH-1:0] i_vec,
  output logic [ACC_WIDTH-1:0]  o_sum
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  logic signed [PROD_WIDTH-1:0] w_prod;
  logic        [ACC_WIDTH-1:0]  w_prod_ext;

  assign w_prod = $signed(i_mat) * $signed(i_vec);
  // Signed size cast: sign-extends into a wider accumulator, truncates into a narrower one
  assign w_prod_ext = ACC_WIDTH'(w_prod);
  assign o_sum = i_acc + w_prod_ext;

endmodule

// File: rtl/spmv_row_mac.sv
// SpMV row multiply-accumulate: sums each CSR row's element products and emits
// one {row index, sum} result per row, including a zero result for empty rows.
module spmv_row_mac
  import spmv_row_mac_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int IDX_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [2*DATA_WIDTH-1:0] s_elem_data,
  input  logic                    s_elem_valid,
  output logic                    s_elem_ready,
  input  logic [LEN_WIDTH-1:0]    s_len_data,
  input  logic                    s_len_valid,
  output logic                    s_len_ready,
  output logic [ACC_WIDTH-1:0]    m_data,
  output logic [IDX_WIDTH-1:0]    m_row,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    busy
);

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_m_data;
  logic [LEN_WIDTH-1:0] r_remaining;
  logic [IDX_WIDTH-1:0] r_row_cnt;
  logic                 r_m_valid;

  logic [DATA_WIDTH-1:0] w_mat;
  logic [DATA_WIDTH-1:0] w_vec;
  logic [ACC_WIDTH-1:0]  w_sum;
  logic                  w_len_acc;
  logic                  w_elem_acc;
  logic                  w_len_zero;

  assign w_mat = s_elem_data[MAT_LSB*DATA_WIDTH +: DATA_WIDTH];
  assign w_vec = s_elem_data[VEC_LSB*DATA_WIDTH +: DATA_WIDTH];

  spmv_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .i_acc (r_acc),
    .i_mat (w_mat),
    .i_vec (w_vec),
    .o_sum (w_sum)
  );

  // m_ready -> s_len_ready is the only combinational input-to-output path
  assign s_elem_ready = (r_state == ST_ACCUM);
  assign s_len_ready  = rstn & ((r_state == ST_IDLE) | ((r_state == ST_EMIT) & m_ready));
  assign busy         = (r_state != ST_IDLE);
  assign m_data       = r_m_data;
  assign m_row        = r_row_cnt;
  assign m_valid      = r_m_valid;

  assign w_len_acc  = s_len_valid & s_len_ready;
  assign w_elem_acc = s_elem_valid & s_elem_ready;
  assign w_len_zero = (s_len_data == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_m_data    <= '0;
      r_remaining <= '0;
      r_row_cnt   <= '0;
      r_m_valid   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_len_acc) begin
            if (w_len_zero) begin
              r_m_data  <= '0;
              r_m_valid <= 1'b1;
              r_state   <= ST_EMIT;
            end else begin
              r_remaining <= s_len_data;
              r_acc       <= '0;
              r_state     <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (w_elem_acc) begin
            r_acc       <= w_sum;
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            if (r_remaining == LEN_WIDTH'(1)) begin
              r_m_data  <= w_sum;
              r_m_valid <= 1'b1;
              r_state   <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (m_ready) begin
            r_row_cnt <= r_row_cnt + IDX_WIDTH'(1);
            // A length taken in the hand-off cycle starts the next row without an IDLE bubble
            if (w_len_acc && w_len_zero) begin
              r_m_data <= '0;
            end else if (w_len_acc) begin
              r_remaining <= s_len_data;
              r_acc       <= '0;
              r_m_valid   <= 1'b0;
              r_state     <= ST_ACCUM;
            end else begin
              r_m_valid <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_row_mac.sv
// Self-checking bench for spmv_row_mac: directed row table, stall/reset sequences,
// a narrow-width build and randomized rows against a queue-based row-sum model.
module tb_spmv_row_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // Default build (A)
  logic [63:0] a_elem_data;
  logic        a_elem_valid, a_elem_ready;
  logic [15:0] a_len_data;
  logic        a_len_valid, a_len_ready;
  logic [63:0] a_m_data;
  logic [31:0] a_m_row;
  logic        a_m_valid, a_m_ready, a_busy;

  // Narrow build (B): 8-bit accumulator, 2-bit row index
  logic [63:0] b_elem_data;
  logic        b_elem_valid, b_elem_ready;
  logic [15:0] b_len_data;
  logic        b_len_valid, b_len_ready;
  logic [7:0]  b_m_data;
  logic [1:0]  b_m_row;
  logic        b_m_valid, b_m_ready, b_busy;

  spmv_row_mac dut_a (
    .clk(clk), .rstn(rstn),
    .s_elem_data(a_elem_data), .s_elem_valid(a_elem_valid), .s_elem_ready(a_elem_ready),
    .s_len_data(a_len_data), .s_len_valid(a_len_valid), .s_len_ready(a_len_ready),
    .m_data(a_m_data), .m_row(a_m_row), .m_valid(a_m_valid), .m_ready(a_m_ready),
    .busy(a_busy)
  );

  spmv_row_mac #(.ACC_WIDTH(8), .IDX_WIDTH(2)) dut_b (
    .clk(clk), .rstn(rstn),
    .s_elem_data(b_elem_data), .s_elem_valid(b_elem_valid), .s_elem_ready(b_elem_ready),
    .s_len_data(b_len_data), .s_len_valid(b_len_valid), .s_len_ready(b_len_ready),
    .m_data(b_m_data), .m_row(b_m_row), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .busy(b_busy)
  );

  typedef struct packed {
    int               len;
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    longint           exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  int     len_q[$];
  int     ea_q[$];
  int     eb_q[$];
  longint exp_d_q[$];
  longint exp_r_q[$];
  longint next_row[2];

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic vec_t mk(input int len, input int a0, input int a1, input int a2, input int a3,
                              input int b0, input int b1, input int b2, input int b3, input longint exp);
    vec_t v;
    v.len = len;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.exp = exp;
    return v;
  endfunction

  task automatic push_elem(input int a, input int b);
    ea_q.push_back(a);
    eb_q.push_back(b);
  endtask

  task automatic push_exp(input int sel, input int len, input longint exp);
    len_q.push_back(len);
    exp_d_q.push_back(exp);
    exp_r_q.push_back(next_row[sel]);
    next_row[sel]++;
  endtask

  // Model: a row's result is the plain sum of its element products, modulo 2^64
  task automatic push_random_row(input int sel);
    int len;
    int a, b;
    longint sum;
    len = $urandom_range(0, 5);
    sum = 0;
    for (int j = 0; j < len; j++) begin
      a = ($urandom_range(0, 7) == 0) ? int'(32'h8000_0000) : int'($urandom);
      b = ($urandom_range(0, 7) == 0) ? int'(32'h7fff_ffff) : int'($urandom);
      push_elem(a, b);
      sum += longint'(a) * longint'(b);
    end
    push_exp(sel, len, sum);
  endtask

  task automatic run_stream(input int sel, input bit rnd, input int budget);
    int cyc = 0;
    int rem = 0;
    int done_cyc = -100;
    bit lv, ev, rdy, lr, er, mv;
    int ld;
    logic [63:0] ed;
    longint md, mr, xd, xr;
    while (exp_d_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      lv  = (len_q.size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
      ev  = (ea_q.size() != 0) && (!rnd || $urandom_range(0, 2) != 0);
      rdy = !rnd || ($urandom_range(0, 3) != 0);
      ld  = lv ? len_q[0] : 0;
      ed  = ev ? {ea_q[0], eb_q[0]} : 64'h0;
      if (sel == 0) begin
        a_len_valid = lv; a_len_data = 16'(ld); a_elem_valid = ev; a_elem_data = ed; a_m_ready = rdy;
      end else begin
        b_len_valid = lv; b_len_data = 16'(ld); b_elem_valid = ev; b_elem_data = ed; b_m_ready = rdy;
      end
      #1;
      lr = (sel == 0) ? a_len_ready : b_len_ready;
      er = (sel == 0) ? a_elem_ready : b_elem_ready;
      mv = (sel == 0) ? a_m_valid : b_m_valid;
      md = (sel == 0) ? longint'(a_m_data) : longint'(b_m_data);
      mr = (sel == 0) ? longint'(a_m_row) : longint'(b_m_row);
      if (mv && rdy) begin
        xd = (sel == 0) ? exp_d_q[0] : (exp_d_q[0] & 64'hff);
        xr = (sel == 0) ? (exp_r_q[0] & 64'hffff_ffff) : (exp_r_q[0] & 64'h3);
        $display("dut%0d result row=%0d data=%0d", sel, mr, md);
        check("row_data", md, xd);
        check("row_index", mr, xr);
        if (!rnd) check("result_latency", longint'(cyc), longint'(done_cyc + 1));
        void'(exp_d_q.pop_front());
        void'(exp_r_q.pop_front());
      end
      if (lv && lr) begin
        if (len_q[0] == 0) done_cyc = cyc;
        else rem = len_q[0];
        void'(len_q.pop_front());
      end
      if (ev && er) begin
        check("elem_inside_row", longint'(rem > 0), 1);
        rem--;
        if (rem == 0) done_cyc = cyc;
        void'(ea_q.pop_front());
        void'(eb_q.pop_front());
      end
      cyc++;
    end
    check("stream_results_left", longint'(exp_d_q.size()), 0);
    check("stream_elems_left", longint'(ea_q.size()), 0);
    @(negedge clk);
    a_len_valid = 0; a_elem_valid = 0; a_m_ready = 0;
    b_len_valid = 0; b_elem_valid = 0; b_m_ready = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int   t;

    tbl[0] = mk(3, 2, -1, 5, 0, 3, 4, 5, 0, 27);
    tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(2, 7, 1, 0, 0, 7, -50, 0, 0, -1);
    tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(2, int'(32'h8000_0000), 2147483647, 0, 0, int'(32'h8000_0000), int'(32'h8000_0000), 0, 0, 64'd2147483648);
    tbl[5] = mk(4, -3, 100000, -100000, 1, 7, 100000, 100000, -1, -22);
    tbl[6] = mk(1, 2, 0, 0, 0, 3, 0, 0, 0, 6);
    tbl[7] = mk(1, 4, 0, 0, 0, -1, 0, 0, 0, -4);
    tbl[8] = mk(1, -6, 0, 0, 0, -6, 0, 0, 0, 36);

    next_row[0] = 0;
    next_row[1] = 0;
    a_elem_data = '0; a_elem_valid = 0; a_len_data = '0; a_len_valid = 0; a_m_ready = 0;
    b_elem_data = '0; b_elem_valid = 0; b_len_data = '0; b_len_valid = 0; b_m_ready = 0;

    // Reset state, with a length and m_ready offered so the rstn gate is exercised
    rstn = 0;
    a_len_valid = 1; a_m_ready = 1; a_elem_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_len_ready", longint'(a_len_ready), 0);
    check("rst_elem_ready", longint'(a_elem_ready), 0);
    check("rst_m_valid", longint'(a_m_valid), 0);
    check("rst_m_data", longint'(a_m_data), 0);
    check("rst_m_row", longint'(a_m_row), 0);
    check("rst_busy", longint'(a_busy), 0);
    @(negedge clk);
    a_len_valid = 0; a_m_ready = 0; a_elem_valid = 0;
    rstn = 1;

    // Directed rows: basic MAC, empty rows, extremes, back-to-back single-element rows
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < tbl[i].len; j++) push_elem(int'(tbl[i].a[j]), int'(tbl[i].b[j]));
      push_exp(0, tbl[i].len, tbl[i].exp);
    end
    run_stream(0, 1'b0, 300);

    // Result held while m_ready is low
    a_m_ready = 0; a_len_valid = 1; a_len_data = 16'd1;
    a_elem_valid = 1; a_elem_data = {32'd4, 32'hffff_fffb};
    t = 0;
    while (!a_m_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    #1;
    check("stall_reach_emit", longint'(a_m_valid), 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      check("stall_m_valid", longint'(a_m_valid), 1);
      check("stall_m_data", longint'(a_m_data), -20);
      check("stall_m_row", longint'(a_m_row), next_row[0]);
      check("stall_len_ready", longint'(a_len_ready), 0);
      check("stall_elem_ready", longint'(a_elem_ready), 0);
    end
    @(negedge clk);
    a_len_valid = 0; a_elem_valid = 0; a_m_ready = 1;
    $display("dut0 result row=%0d data=%0d", a_m_row, $signed(a_m_data));
    @(negedge clk);
    #1;
    check("stall_release_valid", longint'(a_m_valid), 0);
    check("stall_release_busy", longint'(a_busy), 0);
    next_row[0]++;
    a_m_ready = 0;

    // Reset in the middle of a row drops the partial sum
    @(negedge clk);
    a_len_valid = 1; a_len_data = 16'd4;
    @(negedge clk);
    a_len_valid = 0; a_elem_valid = 1; a_elem_data = {32'd3, 32'd3};
    repeat (2) @(negedge clk);
    a_elem_valid = 0;
    #1;
    check("midrow_busy", longint'(a_busy), 1);
    rstn = 0;
    #1;
    check("midrst_m_valid", longint'(a_m_valid), 0);
    check("midrst_m_data", longint'(a_m_data), 0);
    check("midrst_m_row", longint'(a_m_row), 0);
    check("midrst_busy", longint'(a_busy), 0);
    check("midrst_elem_ready", longint'(a_elem_ready), 0);
    @(negedge clk);
    rstn = 1;
    next_row[0] = 0;
    next_row[1] = 0;
    push_elem(3, 3);
    push_exp(0, 1, 9);
    run_stream(0, 1'b0, 50);

    // Randomized rows with random valid gaps and back-pressure
    for (int i = 0; i < 40; i++) push_random_row(0);
    run_stream(0, 1'b1, 20000);

    // Narrow build: accumulator wrap and row-index wrap
    push_elem(127, 1);
    push_elem(1, 1);
    push_exp(1, 2, 128);
    for (int i = 0; i < 4; i++) push_exp(1, 0, 0);
    run_stream(1, 1'b0, 100);
    for (int i = 0; i < 12; i++) push_random_row(1);
    run_stream(1, 1'b1, 5000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
